// File: rtl/dma_rr_scheduler_pkg.sv
// dma_sched_pkg: shared constants and state encoding for the DMA round-robin scheduler
package dma_sched_pkg;
    localparam int NCH  = 4;
    localparam int CH_W = 2;
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        GAP  = 3'b100
    } state_t;
endpackage

// File: rtl/dma_rr_scheduler_if.sv
// dma_sched_if: scheduler-side bundle of channel requests, datapath beat feedback and grant/status outputs
//   req, ch_en  : per-channel request and enable (eligible = req & ch_en)
//   quota       : per-channel beat limit, channel i at [i*BURST_W +: BURST_W], 0 means 2^BURST_W
//   beat, last  : datapath beat completion and end-of-data qualifier
//   grant, busy : one-hot registered grant and its OR
//   done, timeout_err, err_ch : end-of-grant pulses and the last timed-out channel
interface dma_sched_if import dma_sched_pkg::*; #(parameter int BURST_W = 8);
    logic [NCH-1:0]         req;
    logic [NCH-1:0]         ch_en;
    logic [NCH*BURST_W-1:0] quota;
    logic                   beat;
    logic                   last;
    logic [NCH-1:0]         grant;
    logic                   busy;
    logic [NCH-1:0]         done;
    logic                   timeout_err;
    logic [CH_W-1:0]        err_ch;
    modport master (output req, ch_en, quota, beat, last,
                    input  grant, busy, done, timeout_err, err_ch);
    modport slave  (input  req, ch_en, quota, beat, last,
                    output grant, busy, done, timeout_err, err_ch);
endinterface

// File: rtl/dma_rr_scheduler_rr_pick4.sv
// rr_pick4: combinational rotate-priority search over four requesters
//   eligible : candidate mask
//   ptr      : last served index; search starts at ptr+1
//   found    : any candidate present
//   idx      : first candidate at or after ptr+1 (mod 4)
module rr_pick4 import dma_sched_pkg::*; (
    input  logic [NCH-1:0]  eligible,
    input  logic [CH_W-1:0] ptr,
    output logic            found,
    output logic [CH_W-1:0] idx
);
    logic [CH_W-1:0] c;
    always_comb begin
        found = |eligible;
        idx   = '0;
        c     = '0;
        // walk from farthest to nearest so the nearest hit is the one left in idx
        for (int k = NCH; k >= 1; k--) begin
            c   = ptr + CH_W'(k);
            idx = eligible[c] ? c : idx;
        end
    end
endmodule

// File: rtl/dma_rr_scheduler.sv
// dma_rr_scheduler: four-channel round-robin DMA grant scheduler with burst quotas and stall watchdog
//   clk, rst : clock and synchronous active-high reset
//   bus      : dma_sched_if slave side (requests/enables/quotas/beats in, grant/status out)
module dma_rr_scheduler import dma_sched_pkg::*; #(
    parameter int BURST_W = 8,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    dma_sched_if.slave  bus
);
    state_t           state_q, state_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CH_W-1:0]  g_q, g_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic [NCH-1:0]   done_q, done_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;
    logic [CH_W-1:0]  err_q, err_d;
    // one extra bit so a quota of 0 can stand for 2^BURST_W beats
    logic [BURST_W:0] cnt_q, cnt_d;
    logic [BURST_W:0] lim_q, lim_d;
    logic [TO_W-1:0]  wd_q, wd_d;

    logic [NCH-1:0]   elig;
    logic             found;
    logic [CH_W-1:0]  pick;
    logic [BURST_W-1:0] q_sel;
    logic [BURST_W:0] cnt_inc;
    logic [TO_W-1:0]  wd_inc;
    logic             end_last, end_quota, end_dis, end_to, end_ok;

    assign elig      = bus.req & bus.ch_en;
    assign q_sel     = bus.quota[pick*BURST_W +: BURST_W];
    assign cnt_inc   = cnt_q + 1'b1;
    assign wd_inc    = wd_q + 1'b1;
    assign end_last  = bus.beat && bus.last;
    assign end_quota = bus.beat && (cnt_inc == lim_q);
    assign end_dis   = !bus.ch_en[g_q];
    // watchdog expires on the idle cycle that would bring wd to all-ones
    assign end_to    = !bus.beat && (&wd_inc);
    assign end_ok    = end_last || end_quota;

    rr_pick4 u_pick (
        .eligible (elig),
        .ptr      (ptr_q),
        .found    (found),
        .idx      (pick)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        wd_d    = wd_q;
        done_d  = '0;
        to_d    = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (found) begin
                state_d = BUSY;
                g_d     = pick;
                grant_d = NCH'(1) << pick;
                cnt_d   = '0;
                lim_d   = (q_sel == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, q_sel};
                wd_d    = '0;
            end
            BUSY: begin
                cnt_d = bus.beat ? cnt_inc : cnt_q;
                wd_d  = bus.beat ? '0 : wd_inc;
                if (end_ok || end_dis || end_to) begin
                    state_d = GAP;
                    grant_d = '0;
                    ptr_d   = g_q;
                    done_d  = end_ok ? grant_q : '0;
                    to_d    = !end_ok && !end_dis;
                    err_d   = (!end_ok && !end_dis) ? g_q : err_q;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= CH_W'(NCH - 1);
            g_q     <= '0;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
            lim_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            wd_q    <= wd_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = to_q;
    assign bus.err_ch      = err_q;
endmodule
